// File: rtl/pipe_reg_m.sv
// ----------------------------------------------------------------------------
// pipe_reg_m -- elastic pipeline register
//
// A chain of DEPTH data stages, each with its own valid bit, and a
// valid/ready handshake on both sides. It is meant to sit between datapath
// sections (for example IF->ID or EX->MEM) where stalls and squashes happen.
//
// Behaviour:
//   - A stage loads whenever the stage after it can take its contents, or
//     when it is empty. Empty stages (bubbles) therefore collapse even while
//     the output is stalled.
//   - Sustained throughput is one word per cycle. An accepted word reaches
//     the output DEPTH cycles after acceptance when out_ready stays high.
//   - flush clears every valid bit and leaves the data untouched. The word
//     offered on the input in a flush cycle is dropped.
//   - rst clears every valid bit and loads RESET_VAL into every data stage.
//     rst has priority over flush.
//
// Parameters:
//   WIDTH      log2 of the data width; the data bus is 2**WIDTH bits
//   DEPTH      number of register stages (>= 1)
//   RESET_VAL  value loaded into every data stage on reset
//
// Ports:
//   clk        clock; all state updates on posedge
//   rst        synchronous reset, active-high
//   flush      squash all in-flight entries
//   in_valid   upstream presents in_data
//   in_ready   pipe can accept in_data this cycle
//   in_data    upstream data
//   out_valid  last stage holds a valid entry
//   out_ready  downstream accepts out_data this cycle
//   out_data   last-stage data
//   occ        occupancy, 0..DEPTH (present only when PIPE_OCC_EN is defined)
//
// Build option:
//   PIPE_OCC_EN  when defined, adds the occ port and its registered
//                occupancy counter. Without it there is no counter logic.
// ----------------------------------------------------------------------------

module pipe_reg_m #(
    parameter int                  WIDTH     = 5,
    parameter int                  DEPTH     = 2,
    parameter logic [2**WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2**WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**WIDTH-1:0]  out_data
`ifdef PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    localparam int DW = 2**WIDTH;

    // Per-stage state; stage DEPTH-1 is the output stage.
    logic [DEPTH-1:0] valid_q;
    logic [DW-1:0]    data_q [DEPTH];

    // rdy[i] means stage i may load this cycle. rdy[DEPTH] is the downstream
    // ready signal.
    logic [DEPTH:0]   rdy;

    // The source that each stage loads from: the input port for stage 0,
    // otherwise the previous stage.
    logic [DEPTH-1:0] src_valid;
    logic [DW-1:0]    src_data [DEPTH];

    // ------------------------------------------------------------------------
    // Ready chain, built from the output back toward the input.
    // A stage can load if it is empty or if its contents move on this cycle.
    // ------------------------------------------------------------------------
    always_comb begin : ready_chain
        logic [DEPTH:0] chain;
        // NOTE: every variable assigned in always_comb gets a default value
        // first. A path that leaves it unassigned would infer a latch.
        chain        = '0;
        chain[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain[i] = ~valid_q[i] | chain[i+1];
        end
        rdy = chain;
    end

    always_comb begin : stage_sources
        src_valid    = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = valid_q[i-1];
            src_data[i]  = data_q[i-1];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    // ------------------------------------------------------------------------
    // Stage registers.
    // Data is written only when a valid word moves in. A stage that loads a
    // bubble keeps its old data, and only its valid bit drops.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            // NOTE: the data stages are reset on purpose, so that out_data
            // shows a defined RESET_VAL after reset. A plain storage array
            // would normally be left without a reset.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
        end else if (flush) begin
            // Squash only: the data stays as it is and the offered input
            // word is dropped.
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    // NOTE: sequential state uses non-blocking assignments.
                    // Every stage then samples the pre-edge value of its
                    // neighbour, which is what makes this a shift and not a
                    // ripple-through.
                    valid_q[i] <= src_valid[i];
                    if (src_valid[i]) begin
                        data_q[i] <= src_data[i];
                    end
                end
            end
        end
    end

`ifdef PIPE_OCC_EN
    // ------------------------------------------------------------------------
    // Occupancy counter. It tracks popcount(valid_q) from the transfers
    // alone, so no adder tree over valid_q is needed. It cannot wrap: an
    // input transfer needs a free slot, and an output transfer needs a valid
    // last stage.
    // ------------------------------------------------------------------------
    localparam int OW = $clog2(DEPTH + 1);

    logic          in_xfer;
    logic          out_xfer;
    logic [OW-1:0] occ_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   occ_q <= occ_q + OW'(1);
                2'b01:   occ_q <= occ_q - OW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg_m.sv
// ----------------------------------------------------------------------------
// tb_pipe_reg_m -- directed self-checking bench for pipe_reg_m
// (WIDTH=5, DEPTH=2, RESET_VAL=32'hDEAD_BEEF).
//
// Inputs change #1 after a rising edge. Outputs are checked a further #1
// later, well before the next rising edge. The occ checks are compiled in
// only when PIPE_OCC_EN is defined.
// ----------------------------------------------------------------------------

module tb_pipe_reg_m;

    localparam int          WIDTH = 5;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RVAL  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_OCC_EN
    logic [$clog2(DEPTH+1)-1:0] occ;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_reg_m #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RVAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, then let the combinational outputs settle.
    task automatic drive(input logic v, input logic [31:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    // Advance past one rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_occ(input string tag, input int exp);
`ifdef PIPE_OCC_EN
        check(tag, 32'(occ), 32'(exp));
`else
        // Without PIPE_OCC_EN there is no occ port to compare.
`endif
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b1, 32'h0000_0055, 1'b0);

        // ---- 1. Reset for two cycles with in_valid high ----
        cycle();
        cycle();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", out_data, RVAL);
        check("rst_in_ready", 32'(in_ready), 1);
        check_occ("rst_occ", 0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        cycle();
        check("rst_no_accept_a", 32'(out_valid), 0);
        cycle();
        check("rst_no_accept_b", 32'(out_valid), 0);
        check("rst_data_held", out_data, RVAL);

        // ---- 2. Stream 1,2,3 with out_ready=1 ----
        drive(1'b1, 32'h1, 1'b1);
        check("st_in_ready", 32'(in_ready), 1);
        cycle();
        check("st_t1_valid", 32'(out_valid), 0);
        check_occ("st_t1_occ", 1);
        drive(1'b1, 32'h2, 1'b1);
        cycle();
        check("st_t2_valid", 32'(out_valid), 1);
        check("st_t2_data", out_data, 32'h1);
        check_occ("st_t2_occ", 2);
        drive(1'b1, 32'h3, 1'b1);
        check("st_full_in_ready", 32'(in_ready), 1);
        cycle();
        check("st_t3_valid", 32'(out_valid), 1);
        check("st_t3_data", out_data, 32'h2);
        drive(1'b0, 32'h0, 1'b1);
        cycle();
        check("st_t4_valid", 32'(out_valid), 1);
        check("st_t4_data", out_data, 32'h3);
        check_occ("st_t4_occ", 1);
        cycle();
        check("st_t5_valid", 32'(out_valid), 0);
        check_occ("st_t5_occ", 0);

        // ---- 3. Backpressure: offer A,B,C with out_ready=0 ----
        drive(1'b1, 32'hA, 1'b0);
        check("bp_a_in_ready", 32'(in_ready), 1);
        cycle();
        drive(1'b1, 32'hB, 1'b0);
        check("bp_b_in_ready", 32'(in_ready), 1);
        cycle();
        drive(1'b1, 32'hC, 1'b0);
        check("bp_c_in_ready", 32'(in_ready), 0);
        check("bp_full_data", out_data, 32'hA);
        check_occ("bp_full_occ", 2);
        cycle();
        check("bp_hold_valid", 32'(out_valid), 1);
        check("bp_hold_data", out_data, 32'hA);
        check_occ("bp_hold_occ", 2);
        drive(1'b1, 32'hC, 1'b1);
        check("bp_rel_in_ready", 32'(in_ready), 1);
        cycle();
        check("bp_out_b", out_data, 32'hB);
        drive(1'b0, 32'h0, 1'b1);
        cycle();
        check("bp_out_c_valid", 32'(out_valid), 1);
        check("bp_out_c", out_data, 32'hC);
        cycle();
        check("bp_drained", 32'(out_valid), 0);

        // ---- 4. Full pass-through ----
        drive(1'b1, 32'h11, 1'b0);
        cycle();
        drive(1'b1, 32'h12, 1'b0);
        cycle();
        drive(1'b1, 32'h13, 1'b1);
        check("pt_in_ready", 32'(in_ready), 1);
        check("pt_out0", out_data, 32'h11);
        check_occ("pt_occ0", 2);
        cycle();
        check("pt_out1", out_data, 32'h12);
        check_occ("pt_occ1", 2);
        drive(1'b1, 32'h14, 1'b1);
        check("pt_in_ready1", 32'(in_ready), 1);
        cycle();
        check("pt_out2", out_data, 32'h13);
        check_occ("pt_occ2", 2);
        drive(1'b0, 32'h0, 1'b1);
        cycle();
        check("pt_out3", out_data, 32'h14);
        cycle();
        check("pt_drained", 32'(out_valid), 0);

        // ---- 5. Flush with 0x5,0x6 held and 0x7 offered ----
        drive(1'b1, 32'h5, 1'b0);
        cycle();
        drive(1'b1, 32'h6, 1'b0);
        cycle();
        check("fl_pre_data", out_data, 32'h5);
        flush = 1'b1;
        drive(1'b1, 32'h7, 1'b1);
        check("fl_in_ready", 32'(in_ready), 1);
        cycle();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        check("fl_out_valid", 32'(out_valid), 0);
        check("fl_data_kept", out_data, 32'h5);
        check_occ("fl_occ", 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("fl_no_7", 32'(out_valid), 0);
        end
        check("fl_data_still", out_data, 32'h5);

        // ---- 6. Reset mid-stream while full and stalled ----
        drive(1'b1, 32'h21, 1'b0);
        cycle();
        drive(1'b1, 32'h22, 1'b0);
        cycle();
        check("mr_full_in_ready", 32'(in_ready), 0);
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        cycle();
        rst = 1'b0;
        check("mr_out_valid", 32'(out_valid), 0);
        check("mr_out_data", out_data, RVAL);
        check("mr_in_ready", 32'(in_ready), 1);
        check_occ("mr_occ", 0);
        drive(1'b1, 32'h9, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 1'b1);
        check("mr_lat1_valid", 32'(out_valid), 0);
        cycle();
        check("mr_lat2_valid", 32'(out_valid), 1);
        check("mr_lat2_data", out_data, 32'h9);
        cycle();
        check("mr_end_valid", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
